// File: rtl/mul_rsat_pipe.sv
// mul_rsat_pipe: pipelined signed multiplier with valid tracking, selectable
// output slice (arithmetic shift), optional round-half-up and optional
// symmetric saturation, plus per-sample and sticky overflow flags.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   in_valid    a/b carry a sample this cycle
//   a, b        signed operands
//   out_valid   p/ovf carry a result this cycle (PIPE cycles after in_valid)
//   p           rounded/shifted/saturated (or wrapped) product
//   ovf         this sample's shifted product exceeded the OUT_W range
//   ovf_sticky  OR of ovf over output samples since the last clear
//   ovf_clr     synchronous clear of ovf_sticky (a same-cycle set wins)
module mul_rsat_pipe #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int ROUND = 1,
  parameter int SAT   = 1,
  parameter int PIPE  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] p,
  output logic                    ovf,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr
);

  localparam int PW  = A_W + B_W;
  localparam int RW  = PW + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Stage 3 plus the plain delay stages up to PIPE.
  localparam int unsigned NS = PIPE - 2;

  localparam logic signed [RW-1:0] RND  =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] QMAX = (RW'(1) << (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] QMIN = ~QMAX;

  logic signed [A_W-1:0]   a_r;
  logic signed [B_W-1:0]   b_r;
  logic                    v1;
  logic signed [PW-1:0]    prod;
  logic                    v2;

  logic signed [RW-1:0]    r_full;
  logic signed [RW-1:0]    q_full;
  logic signed [OUT_W-1:0] p_n;
  logic                    ovf_n;

  logic [NS-1:0]           vs;
  logic signed [OUT_W-1:0] ps [NS];
  logic [NS-1:0]           os;

  // The extra bit keeps the rounding addition from ever overflowing.
  always_comb begin
    r_full = {prod[PW-1], prod} + RND;
    q_full = r_full >>> SHIFT;
    ovf_n  = (q_full > QMAX) || (q_full < QMIN);
    if (SAT != 0 && q_full > QMAX)
      p_n = QMAX[OUT_W-1:0];
    else if (SAT != 0 && q_full < QMIN)
      p_n = QMIN[OUT_W-1:0];
    else
      p_n = q_full[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      b_r  <= '0;
      v1   <= 1'b0;
      prod <= '0;
      v2   <= 1'b0;
      vs   <= '0;
      os   <= '0;
      for (int unsigned i = 0; i < NS; i++)
        ps[i] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end
      v2 <= v1;
      if (v1)
        prod <= a_r * b_r;
      vs[0] <= v2;
      if (v2) begin
        ps[0] <= p_n;
        os[0] <= ovf_n;
      end
      // Data registers only advance behind a valid bit, so the output
      // holds the last valid result through gaps.
      for (int unsigned i = 1; i < NS; i++) begin
        vs[i] <= vs[i-1];
        if (vs[i-1]) begin
          ps[i] <= ps[i-1];
          os[i] <= os[i-1];
        end
      end
    end
  end

  assign out_valid = vs[NS-1];
  assign p         = ps[NS-1];
  assign ovf       = os[NS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_sticky <= 1'b0;
    else if (out_valid && ovf)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_mul_rsat_pipe.sv
// Bench for mul_rsat_pipe: three instances share stimulus
//   u0: ROUND=1 SAT=1 PIPE=3 (defaults)
//   u1: ROUND=0 SAT=1 PIPE=3
//   u2: ROUND=1 SAT=0 PIPE=5
// Expected results are queued at issue time from an arithmetic model and
// checked by a separate monitor when each instance presents out_valid.
module tb_mul_rsat_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic ovf_clr = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;

  logic               ov  [3];
  logic signed [15:0] pv  [3];
  logic               ofv [3];
  logic               stk [3];

  int pipes [3] = '{3, 3, 5};
  bit rnds  [3] = '{1'b1, 1'b0, 1'b1};
  bit sats  [3] = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    logic signed [15:0] p;
    logic               ovf;
    int unsigned        due;
  } exp_t;

  exp_t sbq [3][$];
  logic signed [15:0] last_p [3];
  logic               last_o [3];

  int unsigned cyc = 0;
  int nchk = 0;
  int nfail = 0;
  int nvalid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mul_rsat_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .ROUND(1), .SAT(1), .PIPE(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov[0]), .p(pv[0]), .ovf(ofv[0]), .ovf_sticky(stk[0]), .ovf_clr(ovf_clr));
  mul_rsat_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .ROUND(0), .SAT(1), .PIPE(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov[1]), .p(pv[1]), .ovf(ofv[1]), .ovf_sticky(stk[1]), .ovf_clr(ovf_clr));
  mul_rsat_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .ROUND(1), .SAT(0), .PIPE(5)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov[2]), .p(pv[2]), .ovf(ofv[2]), .ovf_sticky(stk[2]), .ovf_clr(ovf_clr));

  // Reference: exact product, optional +0.5 LSB, floor division by 2^15,
  // then clamp or keep the low 16 bits.
  task automatic model(input int av, input int bv, input bit rnd, input bit sat,
                       output logic signed [15:0] ep, output logic eo);
    longint prod, q;
    prod = longint'(av) * longint'(bv);
    if (rnd) prod = prod + 16384;
    q = prod / 32768;
    if (prod < 0 && (prod % 32768) != 0) q = q - 1;
    eo = (q > 32767) || (q < -32768);
    if (sat && q > 32767)       ep = 16'sh7fff;
    else if (sat && q < -32768) ep = 16'sh8000;
    else                        ep = 16'(q);
  endtask

  task automatic chk(input string nm, input longint act, input longint expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic signed [15:0] av, input logic signed [15:0] bv);
    logic signed [15:0] ep;
    logic eo;
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(int'(av), int'(bv), rnds[k], sats[k], ep, eo);
      sbq[k].push_back('{p: ep, ovf: eo, due: cyc + pipes[k]});
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic signed [15:0] rnd16();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'sh8000;
    if (r == 1) return 16'sh7fff;
    return 16'($urandom);
  endfunction

  task automatic drain();
    int left;
    for (int i = 0; i < 30; i++) begin
      left = sbq[0].size() + sbq[1].size() + sbq[2].size();
      if (left == 0) break;
      tick();
    end
    chk("drain_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          nvalid++;
          nchk++;
          if (sbq[k].size() == 0) begin
            nfail++;
            $display("FAIL unexpected_valid u%0d: got p=%0d with no sample outstanding at cycle %0d", k, pv[k], cyc);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            if (pv[k] !== e.p || ofv[k] !== e.ovf || cyc != e.due) begin
              nfail++;
              $display("FAIL result u%0d: got p=%0d ovf=%0b cycle=%0d expected p=%0d ovf=%0b cycle=%0d",
                       k, pv[k], ofv[k], cyc, e.p, e.ovf, e.due);
            end
            last_p[k] = e.p;
            last_o[k] = e.ovf;
          end
        end else begin
          nchk++;
          if (pv[k] !== last_p[k] || ofv[k] !== last_o[k]) begin
            nfail++;
            $display("FAIL hold u%0d: got p=%0d ovf=%0b expected p=%0d ovf=%0b",
                     k, pv[k], ofv[k], last_p[k], last_o[k]);
          end
          if (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
            exp_t e;
            e = sbq[k].pop_front();
            nchk++;
            nfail++;
            $display("FAIL missing_valid u%0d: got none expected p=%0d at cycle %0d", k, e.p, e.due);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vb;
    for (int k = 0; k < 3; k++) begin
      last_p[k] = '0;
      last_o[k] = 1'b0;
    end
    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid_u%0d", k), ov[k], 0);
      chk($sformatf("rst_p_u%0d", k), pv[k], 0);
      chk($sformatf("rst_ovf_u%0d", k), ofv[k], 0);
      chk($sformatf("rst_sticky_u%0d", k), stk[k], 0);
    end
    rst = 1'b1;
    idle(2);

    // Q15 0.5 * 0.5, then saturation corner cases.
    issue(16384, 16384);
    idle(6);
    issue(-32768, -32768);
    issue(32767, -32768);
    idle(8);
    for (int k = 0; k < 3; k++)
      chk($sformatf("sticky_after_ovf_u%0d", k), stk[k], 1);

    // Rounding vs truncation on both signs.
    issue(3, 16384);
    issue(-3, 16384);
    idle(8);

    // Back-to-back stream, then stream with random gaps.
    for (int i = 0; i < 100; i++)
      issue(rnd16(), rnd16());
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 2) == 0)
        idle(int'($urandom_range(1, 3)));
      issue(rnd16(), rnd16());
    end
    drain();
    idle(2);

    // Clear sticky, then overlap a clear with an overflowing output.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_cleared_u0", stk[0], 0);
    chk("sticky_cleared_u1", stk[1], 0);
    issue(-32768, -32768);
    idle(2);
    ovf_clr = 1'b1;
    tick();
    chk("sticky_set_wins_u0", stk[0], 1);
    chk("sticky_set_wins_u1", stk[1], 1);
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr_idle_u0", stk[0], 0);
    chk("sticky_clr_idle_u1", stk[1], 0);
    drain();
    idle(2);

    // Reset with two samples in flight.
    issue(16384, 16384);
    issue(-32768, -32768);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_out_valid_u%0d", k), ov[k], 0);
      chk($sformatf("midrst_p_u%0d", k), pv[k], 0);
      chk($sformatf("midrst_ovf_u%0d", k), ofv[k], 0);
      chk($sformatf("midrst_sticky_u%0d", k), stk[k], 0);
      sbq[k].delete();
      last_p[k] = '0;
      last_o[k] = 1'b0;
    end
    idle(2);
    rst = 1'b1;
    vb = nvalid;
    idle(10);
    chk("no_valid_after_reset", nvalid - vb, 0);

    issue(16384, 16384);
    idle(6);
    issue(-32768, -32768);
    issue(32767, -32768);
    drain();
    idle(2);
    for (int k = 0; k < 3; k++)
      chk($sformatf("sticky_after_reset_ovf_u%0d", k), stk[k], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
